ram_loader: RTL and testbench

Program loader for the 8-bit CPU. It accepts a stream of program bytes over a valid/ready handshake and writes them into the 16-byte RAM through the shared bus and the input/MAR register, using the same active-low strobes the control block drives. While it owns the bus it holds the CPU in reset. When loading ends it releases the bus and lets the CPU run from address 0.

---
 rtl/cpu8_pkg.sv | 24 ++
 rtl/ram_loader.sv | 152 +++++++++++++++
 tb/tb_ram_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu8_pkg.sv
// Shared types and constants for the 8-bit CPU blocks.
// Revision 1.0 - initial release
`default_nettype none

package cpu8_pkg;

  localparam int LDR_RAM_BYTES = 16;
  localparam int LDR_ADDR_W    = 4;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  typedef enum logic [2:0] {
    LDR_IDLE      = 3'd0,
    LDR_WAIT_BYTE = 3'd1,
    LDR_SET_ADDR  = 3'd2,
    LDR_SET_DATA  = 3'd3,
    LDR_WRITE     = 3'd4,
    LDR_FULL      = 3'd5
  } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_loader.sv
// Program loader: streams bytes into CPU RAM via the MAR/MDR strobes while holding the CPU in reset.
// Revision 1.0 - initial release
`default_nettype none

module ram_loader
  import cpu8_pkg::*;
#(
  parameter int RAM_BYTES = LDR_RAM_BYTES,
  parameter int ADDR_W    = LDR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              nLma,
  output logic              nLmd,
  output logic              nLr,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   byte_count,
  output logic              full
);

  localparam int CW = ADDR_W + 1;

  ldr_state_t          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic [7:0]          r_data;
  logic [7:0]          r_bus_out;
  logic                r_bus_oe;
  logic                r_nlma;
  logic                r_nlmd;
  logic                r_nlr;
  logic                r_in_ready;
  logic                r_cpu_rst_n;

  // Outputs are registered against the next state, so each strobe is
  // glitch-free and lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LDR_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_data      <= '0;
      r_bus_out   <= '0;
      r_bus_oe    <= 1'b0;
      r_nlma      <= STROBE_OFF;
      r_nlmd      <= STROBE_OFF;
      r_nlr       <= STROBE_OFF;
      r_in_ready  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_nlma     <= STROBE_OFF;
      r_nlmd     <= STROBE_OFF;
      r_nlr      <= STROBE_OFF;
      r_bus_oe   <= 1'b0;
      r_in_ready <= 1'b0;

      unique case (r_state)
        LDR_IDLE: begin
          if (load_mode) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cpu_rst_n <= 1'b0;
            r_state     <= LDR_WAIT_BYTE;
          end else begin
            r_cpu_rst_n <= 1'b1;
          end
        end

        LDR_WAIT_BYTE: begin
          if (in_valid) begin
            r_data    <= in_data;
            r_bus_out <= 8'(r_addr);
            r_bus_oe  <= 1'b1;
            r_nlma    <= STROBE_ON;
            r_state   <= LDR_SET_ADDR;
          end else if (!load_mode) begin
            r_cpu_rst_n <= 1'b1;
            r_state     <= LDR_IDLE;
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        LDR_SET_ADDR: begin
          r_bus_out <= r_data;
          r_bus_oe  <= 1'b1;
          r_nlmd    <= STROBE_ON;
          r_state   <= LDR_SET_DATA;
        end

        LDR_SET_DATA: begin
          r_nlr   <= STROBE_ON;
          r_state <= LDR_WRITE;
        end

        LDR_WRITE: begin
          if (r_count != CW'(RAM_BYTES)) begin
            r_count <= r_count + CW'(1);
          end
          // The last location parks in FULL so the address never wraps.
          if (r_addr == ADDR_W'(RAM_BYTES - 1)) begin
            r_full  <= 1'b1;
            r_state <= LDR_FULL;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (load_mode) begin
              r_in_ready <= 1'b1;
              r_state    <= LDR_WAIT_BYTE;
            end else begin
              r_cpu_rst_n <= 1'b1;
              r_state     <= LDR_IDLE;
            end
          end
        end

        LDR_FULL: begin
          if (!load_mode) begin
            r_cpu_rst_n <= 1'b1;
            r_state     <= LDR_IDLE;
          end
        end

        default: begin
          r_state <= LDR_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign bus_out    = r_bus_out;
  assign bus_oe     = r_bus_oe;
  assign nLma       = r_nlma;
  assign nLmd       = r_nlmd;
  assign nLr        = r_nlr;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign byte_count = r_count;
  assign full       = r_full;

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// Randomized self-checking bench for ram_loader with a RAM/MAR/MDR environment model.
// Revision 1.0 - initial release
`default_nettype none

module tb_ram_loader;

  localparam int RAM_BYTES = 16;
  localparam int ADDR_W    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_mode = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_ready;
  logic [7:0]      bus_out;
  logic            bus_oe;
  logic            nLma;
  logic            nLmd;
  logic            nLr;
  logic            cpu_rst_n;
  logic [ADDR_W:0] byte_count;
  logic            full;

  ram_loader #(.RAM_BYTES(RAM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_mode  (load_mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .nLma       (nLma),
    .nLmd       (nLmd),
    .nLr        (nLr),
    .cpu_rst_n  (cpu_rst_n),
    .byte_count (byte_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  // Environment: MAR, input data register and RAM as the CPU wires them.
  logic [7:0] mar = 8'h00;
  logic [7:0] mdr = 8'h00;
  logic [7:0] mem [RAM_BYTES];

  always @(posedge clk) begin
    if (!nLma && bus_oe) mar <= bus_out;
    if (!nLmd && bus_oe) mdr <= bus_out;
    if (!nLr) mem[mar[ADDR_W-1:0]] <= mdr;
  end

  // Reference model
  int         exp_addr  = 0;
  int         exp_count = 0;
  bit         exp_full  = 1'b0;
  logic [7:0] exp_mem   [RAM_BYTES];
  bit         exp_valid [RAM_BYTES];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram();
    for (int i = 0; i < RAM_BYTES; i++) begin
      if (exp_valid[i]) chk($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(exp_mem[i]));
    end
  endtask

  task automatic start_load();
    load_mode = 1'b1;
    tick();
    exp_addr  = 0;
    exp_count = 0;
    exp_full  = 1'b0;
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_cpurst", 32'(cpu_rst_n), 32'd0);
    chk("start_full", 32'(full), 32'd0);
    chk("start_count", 32'(byte_count), 32'd0);
  endtask

  task automatic stop_load();
    load_mode = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("stop_cpurst", 32'(cpu_rst_n), 32'd1);
    chk("stop_ready", 32'(in_ready), 32'd0);
    chk("stop_full", 32'(full), 32'(exp_full));
    chk("stop_count", 32'(byte_count), 32'(exp_count));
  endtask

  // mode: 0 normal, 1..3 drop load_mode in cycle A+mode, 4 async reset in SET_ADDR
  task automatic send_byte(input logic [7:0] b, input int gap, input int mode, output int waited);
    bit accepted;
    accepted = 1'b0;
    waited   = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      else waited++;
      tick();
    end
    if (!accepted) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    in_data = ~b;
    chk("sa_strobes", {29'd0, nLma, nLmd, nLr}, 32'b011);
    chk("sa_oe", 32'(bus_oe), 32'd1);
    chk("sa_bus", 32'(bus_out), 32'(exp_addr));
    chk("sa_ready", 32'(in_ready), 32'd0);
    chk("sa_cpurst", 32'(cpu_rst_n), 32'd0);
    if (mode == 4) begin
      rst_n     = 1'b0;
      load_mode = 1'b0;
      in_valid  = 1'b0;
      #1;
      exp_valid[exp_addr] = 1'b0;
      exp_addr  = 0;
      exp_count = 0;
      exp_full  = 1'b0;
      chk("ar_strobes", {29'd0, nLma, nLmd, nLr}, 32'b111);
      chk("ar_oe", 32'(bus_oe), 32'd0);
      chk("ar_count", 32'(byte_count), 32'd0);
      chk("ar_cpurst", 32'(cpu_rst_n), 32'd0);
      chk("ar_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("ar_release_cpurst", 32'(cpu_rst_n), 32'd1);
      chk("ar_idle_ready", 32'(in_ready), 32'd0);
      return;
    end
    if (mode == 1) load_mode = 1'b0;
    tick();
    chk("sd_strobes", {29'd0, nLma, nLmd, nLr}, 32'b101);
    chk("sd_oe", 32'(bus_oe), 32'd1);
    chk("sd_bus", 32'(bus_out), 32'(b));
    if (mode == 2) load_mode = 1'b0;
    tick();
    chk("wr_strobes", {29'd0, nLma, nLmd, nLr}, 32'b110);
    chk("wr_oe", 32'(bus_oe), 32'd0);
    if (mode == 3) load_mode = 1'b0;
    exp_mem[exp_addr]   = b;
    exp_valid[exp_addr] = 1'b1;
    if (exp_count < RAM_BYTES) exp_count++;
    if (exp_addr == RAM_BYTES - 1) exp_full = 1'b1;
    else exp_addr++;
    tick();
    in_valid = 1'b0;
    chk("post_strobes", {28'd0, nLma, nLmd, nLr, bus_oe}, 32'b1110);
    chk("post_count", 32'(byte_count), 32'(exp_count));
    chk("post_full", 32'(full), 32'(exp_full));
    chk("post_ready", 32'(in_ready), 32'(!exp_full && load_mode));
    chk("post_cpurst", 32'(cpu_rst_n), 32'(!exp_full && !load_mode));
  endtask

  initial begin
    int w;
    int n;
    for (int i = 0; i < RAM_BYTES; i++) begin
      exp_mem[i]   = 8'h00;
      exp_valid[i] = 1'b0;
    end

    // Reset
    repeat (3) tick();
    chk("rst_strobes", {28'd0, nLma, nLmd, nLr, bus_oe}, 32'b1110);
    chk("rst_cpurst", 32'(cpu_rst_n), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_bus", 32'(bus_out), 32'd0);
    #3 rst_n = 1'b1;
    #1 chk("rel_cpurst_before_edge", 32'(cpu_rst_n), 32'd0);
    tick();
    chk("rel_cpurst", 32'(cpu_rst_n), 32'd1);

    // Single byte
    start_load();
    send_byte(8'hA5, 0, 0, w);
    check_ram();
    stop_load();

    // Full back-to-back load, then an ignored 17th byte
    start_load();
    for (int i = 0; i < RAM_BYTES; i++) begin
      send_byte(8'(8'h10 + i), 0, 0, w);
      chk("b2b_latency", 32'(w), 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("full_quiet", {27'd0, in_ready, nLma, nLmd, nLr, bus_oe}, 32'b01110);
    end
    in_valid = 1'b0;
    chk("full_count", 32'(byte_count), 32'(RAM_BYTES));
    chk("full_flag", 32'(full), 32'd1);
    check_ram();
    stop_load();

    // Random partial load with random gaps
    start_load();
    n = $urandom_range(4, 12);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), $urandom_range(0, 3), 0, w);
    stop_load();
    check_ram();

    // Drop load_mode in SET_DATA of byte 3
    start_load();
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 0, 0, w);
    send_byte(8'h3C, 1, 2, w);
    chk("drop_count", 32'(byte_count), 32'd3);
    check_ram();

    // Random drop point
    start_load();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), $urandom_range(0, 2), 0, w);
    send_byte(8'($urandom), 0, $urandom_range(1, 3), w);
    check_ram();

    // Random complete load, then reload
    start_load();
    for (int i = 0; i < RAM_BYTES; i++) send_byte(8'($urandom), $urandom_range(0, 2), 0, w);
    check_ram();
    stop_load();
    start_load();
    send_byte(8'($urandom), 0, 0, w);
    check_ram();
    stop_load();

    // Async reset during SET_ADDR, then load again
    start_load();
    send_byte(8'($urandom), 0, 0, w);
    send_byte(8'($urandom), 0, 4, w);
    start_load();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(0, 2), 0, w);
    stop_load();
    check_ram();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
